fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, width of every PC and address signal.
REQ-002 Parameter DATA_WIDTH, default 32, instruction width.
REQ-003 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port imem_addr  output  ADDRESS_WIDTH  byte address driven to the instruction memory.
REQ-007 Port imem_instr  input  DATA_WIDTH  instruction returned combinationally by the memory for imem_addr in the same cycle.
REQ-008 Port redirect_en  input  1  branch/jump taken; flush the queue and restart fetch.
REQ-009 Port redirect_pc  input  ADDRESS_WIDTH  restart address, sampled when redirect_en=1.
REQ-010 Port out_valid  output  1  head entry is valid for decode.
REQ-011 Port out_ready  input  1  decode accepts the head entry this cycle.
REQ-012 Port out_instr  output  DATA_WIDTH  head instruction.
REQ-013 Port out_pc  output  ADDRESS_WIDTH  PC of the head instruction.
REQ-014 Port misaligned  output  1  sticky flag: a redirect target had nonzero bits [1:0].

Function
REQ-015 Internal fetch_pc register; imem_addr SHALL equal fetch_pc combinationally.
REQ-016 Two-entry FIFO of {pc, instr}; occupancy count 0/1/2 = EMPTY/PARTIAL/FULL.
REQ-017 pop = out_valid & out_ready; out_valid SHALL be 1 iff count != 0.
REQ-018 push = !redirect_en & (count < 2 | pop); on push, enqueue {fetch_pc, imem_instr} at tail and fetch_pc <= fetch_pc + 4.
REQ-019 When push=0 and no redirect, fetch_pc holds (no fetch advance while FULL and not popping).
REQ-020 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; throughput one instruction/cycle with out_ready held high.
REQ-021 fetch_pc increment wraps modulo 2^ADDRESS_WIDTH (32'hFFFFFFFC + 4 -> 32'h00000000).
REQ-022 out_instr/out_pc SHALL present the head entry combinationally; when count=0, out_instr = 32'h00000013 (NOP) and out_pc = fetch_pc.
REQ-023 redirect_en=1 has priority over push and pop: next cycle count=0, fetch_pc = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00}; the head, if valid that cycle, is discarded, not consumed.
REQ-024 Redirect with redirect_pc[1:0] != 0 SHALL set misaligned=1; it stays 1 until rst.
REQ-025 Redirect latency: target instruction appears at out_valid two cycles after the redirect edge (one cycle fetch-enqueue, then visible).
REQ-026 Back-to-back redirects: last one wins; queue remains empty while redirect_en stays 1.
REQ-027 No combinational path from out_ready or redirect_en to imem_addr.

Reset
REQ-028 While rst=1 at a clock edge: fetch_pc <= RESET_PC, count <= 0, misaligned <= 0, FIFO contents don't-care.
REQ-029 During and in the cycle after reset: out_valid=0, out_instr=32'h00000013, imem_addr=RESET_PC.
REQ-030 rst asserted mid-operation SHALL override redirect_en, push and pop in the same cycle.
REQ-031 First instruction (pc=RESET_PC) valid at out_valid one cycle after the first non-reset edge.

Verification
REQ-032 Reset, out_ready=1, memory word at addr N = N -> out_pc sequence 0,4,8,12 on consecutive cycles, out_instr = out_pc, no bubbles.
REQ-033 out_ready=0 for 5 cycles after reset -> count saturates at 2, imem_addr holds 8, out_pc=0; release -> outputs 0,4,8 in order, no loss/duplication.
REQ-034 Redirect to 32'h00000100 while FULL with out_ready=1 -> head not consumed, out_valid=0 next cycle, next out_pc=32'h00000100, misaligned=0.
REQ-035 Redirect to 32'h00000102 -> fetch restarts at 32'h00000100, misaligned=1 and remains 1 until rst.
REQ-036 Redirect to 32'hFFFFFFF8, out_ready=1 -> out_pc 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000.
REQ-037 rst asserted with count=2 and redirect_en=1 -> next cycle out_valid=0, imem_addr=RESET_PC, misaligned=0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential PC generation feeding a two-entry
// {pc, instr} queue toward decode, with taken-branch redirect and a sticky
// misaligned-target flag.
module fetch_queue #(
  parameter int unsigned                 ADDRESS_WIDTH = 32,
  parameter int unsigned                 DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]    RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_instr,
  input  logic                     redirect_en,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic                     misaligned
);

  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_t;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    instr;
  } entry_t;

  occ_t                     state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  entry_t                   head_q, tail_q;
  logic                     pop, push;

  // Fetch address comes straight from a register, so nothing combinational
  // from decode handshakes or redirect reaches the memory address.
  assign imem_addr = fetch_pc;

  // Handshake decode and occupancy next-state; redirect empties the queue.
  always_comb begin
    pop       = (state != EMPTY) && out_ready;
    push      = !redirect_en && ((state != FULL) || pop);
    state_nxt = state;
    if (redirect_en) begin
      state_nxt = EMPTY;
    end else begin
      unique case ({push, pop})
        2'b10: state_nxt = (state == EMPTY) ? PARTIAL : FULL;
        2'b01: state_nxt = (state == FULL) ? PARTIAL : EMPTY;
        default: state_nxt = state;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Fetch PC advance/redirect and sticky misaligned-target flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      misaligned <= 1'b0;
    end else if (redirect_en) begin
      fetch_pc <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) misaligned <= 1'b1;
    end else if (push) begin
      fetch_pc <= fetch_pc + ADDRESS_WIDTH'(4);
    end
  end

  // Queue storage as a shift pair: head_q is always the oldest entry. On a
  // pop the tail slides into the head, and the new word lands in whichever
  // slot is the first free one after that slide.
  always_ff @(posedge clk) begin
    if (pop) head_q <= tail_q;
    if (push) begin
      if ((state == EMPTY) || ((state == PARTIAL) && pop))
        head_q <= '{pc: fetch_pc, instr: imem_instr};
      else
        tail_q <= '{pc: fetch_pc, instr: imem_instr};
    end
  end

  // Head presentation; an empty queue shows a NOP at the current fetch PC.
  always_comb begin
    out_valid = (state != EMPTY);
    out_instr = NOP_INSTR;
    out_pc    = fetch_pc;
    if (state != EMPTY) begin
      out_instr = head_q.instr;
      out_pc    = head_q.pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: memory returns its own address as the
// instruction word; a scoreboard of expected {pc} values is loaded whenever
// fetch (re)starts and drained whenever decode accepts the head.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misaligned;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned pops   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  assign imem_instr = imem_addr;

  fetch_queue #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .RESET_PC     (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .misaligned (misaligned)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Restart the expected stream at an aligned start address.
  task automatic load_seq(input logic [31:0] start);
    logic [31:0] pc;
    exp_q.delete();
    pc = start;
    for (int i = 0; i < 24; i++) begin
      exp_q.push_back(pc);
      pc = pc + 32'd4;
    end
  endtask

  // One clock: sample at negedge, score an accepted head, then advance to
  // just after the rising edge so the caller can drive new inputs.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk);
    if (out_valid && out_ready && !redirect_en && !rst) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", out_pc, e);
        check("sb_instr", out_instr, e);
        pops++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_valid(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      #1 check("no_bubble", {31'd0, out_valid}, 32'd1);
      cycle();
    end
  endtask

  initial begin
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    cycle();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'h13);
    check("rst_addr", imem_addr, 32'h0);
    cycle();
    rst = 1'b0;
    load_seq(32'h0);
    // cycle after reset: still empty, NOP at RESET_PC
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_instr", out_instr, 32'h13);
    check("post_rst_pc", out_pc, 32'h0);
    cycle();
    check("first_valid", {31'd0, out_valid}, 32'd1);

    // stall: queue saturates at two entries, fetch holds at 8
    for (int i = 0; i < 4; i++) cycle();
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    check("stall_addr", imem_addr, 32'h8);
    check("stall_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    run_valid(6);
    check("drain_pops", pops, 32'd6);

    // redirect while full with ready high: head discarded
    out_ready = 1'b0;
    cycle(); cycle(); cycle();
    check("full_addr_hold", imem_addr, exp_q[0] + 32'd8);
    out_ready = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect_en = 1'b0;
    load_seq(32'h100);
    check("redir_valid", {31'd0, out_valid}, 32'd0);
    check("redir_addr", imem_addr, 32'h100);
    check("redir_misal", {31'd0, misaligned}, 32'd0);
    cycle();
    run_valid(3);

    // misaligned target
    redirect_en = 1'b1; redirect_pc = 32'h102;
    cycle();
    redirect_en = 1'b0;
    load_seq(32'h100);
    check("misal_addr", imem_addr, 32'h100);
    check("misal_set", {31'd0, misaligned}, 32'd1);
    cycle();
    run_valid(3);

    // back-to-back redirects: last wins, queue stays empty
    redirect_en = 1'b1; redirect_pc = 32'h200;
    cycle();
    check("b2b_empty", {31'd0, out_valid}, 32'd0);
    redirect_pc = 32'h300;
    cycle();
    check("b2b_empty2", {31'd0, out_valid}, 32'd0);
    redirect_en = 1'b0;
    load_seq(32'h300);
    check("b2b_addr", imem_addr, 32'h300);
    cycle();
    run_valid(2);
    check("misal_sticky", {31'd0, misaligned}, 32'd1);

    // wrap of the fetch address
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect_en = 1'b0;
    load_seq(32'hFFFF_FFF8);
    cycle();
    run_valid(3);
    check("wrap_pops_left", exp_q[0], 32'h4);

    // reset overrides a simultaneous redirect while full
    out_ready = 1'b0;
    cycle(); cycle(); cycle();
    check("pre_rst_full", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h402;
    cycle();
    rst = 1'b0; redirect_en = 1'b0;
    load_seq(32'h0);
    check("rst_ovr_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ovr_addr", imem_addr, 32'h0);
    check("rst_ovr_misal", {31'd0, misaligned}, 32'd0);
    out_ready = 1'b1;
    cycle();
    run_valid(4);
    check("final_next", exp_q[0], 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
